// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Optional feature macro: WB_RR_EN (round-robin arbitration).
package regfile_pkg;

  localparam int REG_AW          = 5;
  localparam int REG_DW          = 32;
  localparam int WB_NREQ_DEFAULT = 3;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] wreg;
    logic [REG_DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus, register-file write port and bypass signals.
// master = requesters/datapath side, slave = arbiter side.
interface regfile_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) ();

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_reg;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;

  logic               RegWrite;
  logic [AW-1:0]      WriteReg;
  logic [DW-1:0]      WriteData;

  logic [AW-1:0]      Read1;
  logic [AW-1:0]      Read2;
  logic               fwd1_hit;
  logic               fwd2_hit;

  modport master (
    output req_valid, req_reg, req_data,
    output Read1, Read2,
    input  req_ready,
    input  RegWrite, WriteReg, WriteData,
    input  fwd1_hit, fwd2_hit
  );

  modport slave (
    input  req_valid, req_reg, req_data,
    input  Read1, Read2,
    output req_ready,
    output RegWrite, WriteReg, WriteData,
    output fwd1_hit, fwd2_hit
  );

endinterface

// File: rtl/regfile_wb_arbiter_picker.sv
// Rotated priority encoder: first set request at or after start wins.
// start = 0 gives plain lowest-index-first priority.
module wb_rr_picker #(
  parameter int NREQ = 3,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   start_i,
  output logic [NREQ-1:0] gnt_o
);

  logic found;
  int   idx;

  // scan NREQ positions beginning at start_i, wrapping
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(start_i) + k) % NREQ;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NREQ writeback sources.
// Define WB_RR_EN for round-robin; otherwise lowest index wins.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = WB_NREQ_DEFAULT,
  parameter int AW   = REG_AW,
  parameter int DW   = REG_DW
) (
  input logic               clock,
  input logic               reset,
  regfile_wb_arbiter_if.slave wb
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  wb_req_t         req_s [NREQ];
  logic [NREQ-1:0] vld;
  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gidx;
  logic            accept;
  logic [PW-1:0]   start;

  logic            regwrite_q, regwrite_d;
  logic [AW-1:0]   writereg_q, writereg_d;
  logic [DW-1:0]   writedata_q, writedata_d;

  // unpack the flat request buses; no grant is offered in reset
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_s[i].valid = wb.req_valid[i];
      req_s[i].wreg  = REG_AW'(wb.req_reg[i*AW +: AW]);
      req_s[i].data  = REG_DW'(wb.req_data[i*DW +: DW]);
      vld[i]         = req_s[i].valid & ~reset;
    end
  end

`ifdef WB_RR_EN
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;

  assign start = rr_ptr_q;

  // pointer moves just past the winner; holds when idle
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (NREQ == 1) begin
      rr_ptr_d = '0;
    end else if (accept) begin
      if (gidx == PW'(NREQ-1)) rr_ptr_d = '0;
      else                     rr_ptr_d = gidx + 1'b1;
    end
  end

  // round-robin pointer register
  always_ff @(posedge clock) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`else
  assign start = '0;
`endif

  wb_rr_picker #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req_i   (vld),
    .start_i (start),
    .gnt_o   (gnt)
  );

  assign wb.req_ready = gnt;
  assign accept       = |gnt;

  // one-hot grant to index
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) gidx = PW'(i);
    end
  end

  // winner drives the write port; r0 writes are swallowed
  always_comb begin
    regwrite_d  = 1'b0;
    writereg_d  = writereg_q;
    writedata_d = writedata_q;
    if (accept) begin
      writereg_d  = AW'(req_s[gidx].wreg);
      writedata_d = DW'(req_s[gidx].data);
      regwrite_d  = (req_s[gidx].wreg != REG_ZERO);
    end
  end

  // registered write port
  always_ff @(posedge clock) begin
    if (reset) begin
      regwrite_q  <= 1'b0;
      writereg_q  <= '0;
      writedata_q <= '0;
    end else begin
      regwrite_q  <= regwrite_d;
      writereg_q  <= writereg_d;
      writedata_q <= writedata_d;
    end
  end

  assign wb.RegWrite  = regwrite_q;
  assign wb.WriteReg  = writereg_q;
  assign wb.WriteData = writedata_q;

  assign wb.fwd1_hit = regwrite_q & (writereg_q == wb.Read1)
                     & (wb.Read1 != '0);
  assign wb.fwd2_hit = regwrite_q & (writereg_q == wb.Read2)
                     & (wb.Read2 != '0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (NREQ=3, AW=5, DW=32).
// Expectations follow WB_RR_EN when it is defined.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

`ifdef WB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clock;
  logic reset;
  int   total;
  int   bad;

  regfile_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) wbi ();

  regfile_wb_arbiter #(
    .NREQ (NREQ),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .wb    (wbi)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] r,
                         input logic [DW-1:0] d);
    wbi.req_reg[i*AW +: AW]  = r;
    wbi.req_data[i*DW +: DW] = d;
  endtask

  initial begin
    int g;
    total = 0;
    bad   = 0;

    reset         = 1'b1;
    wbi.req_valid = 3'b111;
    wbi.req_reg   = '0;
    wbi.req_data  = '0;
    wbi.Read1     = '0;
    wbi.Read2     = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), 32'h100 + i);

    step();
    step();
    chk("rst_ready", 64'(wbi.req_ready), 64'h0);
    chk("rst_we",    64'(wbi.RegWrite),  64'h0);
    chk("rst_wreg",  64'(wbi.WriteReg),  64'h0);
    chk("rst_wdata", 64'(wbi.WriteData), 64'h0);
    chk("rst_fwd1",  64'(wbi.fwd1_hit),  64'h0);

    reset = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) begin
      g = RR ? (k % 3) : 0;
      chk("arb_ready", 64'(wbi.req_ready), 64'(1 << g));
      step();
      chk("arb_we",    64'(wbi.RegWrite), 64'h1);
      chk("arb_wreg",  64'(wbi.WriteReg), 64'(g + 1));
      chk("arb_wdata", 64'(wbi.WriteData), 64'(32'h100 + g));
    end

    wbi.req_valid = '0;
    step();
    chk("idle_we",   64'(wbi.RegWrite), 64'h0);
    chk("idle_hold", 64'(wbi.WriteReg), 64'(g + 1));

    set_req(0, 5'd7, 32'hDEADBEEF);
    wbi.req_valid = 3'b001;
    #1;
    chk("sw_ready", 64'(wbi.req_ready), 64'h1);
    step();
    wbi.req_valid = '0;
    chk("sw_we",    64'(wbi.RegWrite),  64'h1);
    chk("sw_wreg",  64'(wbi.WriteReg),  64'h7);
    chk("sw_wdata", 64'(wbi.WriteData), 64'hDEADBEEF);
    wbi.Read1 = 5'd7;
    #1;
    chk("sw_fwd1", 64'(wbi.fwd1_hit), 64'h1);
    step();
    chk("sw_we_off", 64'(wbi.RegWrite),  64'h0);
    chk("sw_hold",   64'(wbi.WriteData), 64'hDEADBEEF);
    chk("sw_fwd1_off", 64'(wbi.fwd1_hit), 64'h0);

    set_req(1, 5'd0, 32'h1234);
    wbi.Read1     = '0;
    wbi.req_valid = 3'b010;
    #1;
    chk("r0_ready", 64'(wbi.req_ready), 64'h2);
    step();
    wbi.req_valid = '0;
    chk("r0_we",    64'(wbi.RegWrite),  64'h0);
    chk("r0_wreg",  64'(wbi.WriteReg),  64'h0);
    chk("r0_wdata", 64'(wbi.WriteData), 64'h1234);
    chk("r0_fwd1",  64'(wbi.fwd1_hit),  64'h0);

    for (int i = 0; i < NREQ; i++) set_req(i, 5'd5, 32'hA0 + i);
    wbi.req_valid = 3'b111;
    #1;
    g = RR ? 2 : 0;
    chk("ptr_ready", 64'(wbi.req_ready), 64'(1 << g));
    step();
    wbi.req_valid = '0;
    chk("byp_wdata", 64'(wbi.WriteData), 64'(32'hA0 + g));
    wbi.Read1 = 5'd5;
    wbi.Read2 = 5'd0;
    #1;
    chk("byp_fwd1", 64'(wbi.fwd1_hit), 64'h1);
    chk("byp_fwd2", 64'(wbi.fwd2_hit), 64'h0);
    wbi.Read1 = 5'd6;
    wbi.Read2 = 5'd5;
    #1;
    chk("byp_fwd1_miss", 64'(wbi.fwd1_hit), 64'h0);
    chk("byp_fwd2_hit",  64'(wbi.fwd2_hit), 64'h1);
    step();

    set_req(0, 5'd9, 32'h99);
    wbi.req_valid = 3'b001;
    #1;
    chk("mid_ready", 64'(wbi.req_ready), 64'h1);
    step();
    chk("mid_we",   64'(wbi.RegWrite), 64'h1);
    chk("mid_wreg", 64'(wbi.WriteReg), 64'h9);
    reset         = 1'b1;
    wbi.req_valid = 3'b111;
    #1;
    chk("mid_rst_ready", 64'(wbi.req_ready), 64'h0);
    step();
    chk("mid_rst_we",   64'(wbi.RegWrite), 64'h0);
    chk("mid_rst_wreg", 64'(wbi.WriteReg), 64'h0);
    chk("mid_rst_fwd2", 64'(wbi.fwd2_hit), 64'h0);
    reset = 1'b0;
    #1;
    chk("rel_ready", 64'(wbi.req_ready), 64'h1);
    wbi.req_valid = '0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
